// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: shared stage payload types, handshake struct and skid FSM states.
package pipe_skid_reg_pkg;
    localparam int PERF_CNT_W = 16;

    typedef logic [PERF_CNT_W-1:0] perf_cnt_t;

    typedef struct packed {
        logic valid;
        logic ready;
    } stage_hs_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  op;
    } decode_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic [7:0]  op;
    } execute_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wr_en;
    } memory_data_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wr_en;
    } writeback_data_t;

    localparam int FETCH_W     = $bits(fetch_data_t);
    localparam int DECODE_W    = $bits(decode_data_t);
    localparam int EXECUTE_W   = $bits(execute_data_t);
    localparam int MEMORY_W    = $bits(memory_data_t);
    localparam int WRITEBACK_W = $bits(writeback_data_t);
endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage register with optional two-entry skid,
// flush and saturating stall/bubble performance counters.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH         = 64,
    parameter int               SKID          = 1,
    parameter int               CNT_W         = PERF_CNT_W,
    parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    input  logic             cnt_clr
);
    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             in_fire, out_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_PAYLOAD;
            skid_q  <= RESET_PAYLOAD;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // FULL is only reachable with a skid entry; without one a HALF input fire implies an output fire.
    always_comb begin
        state_d = flush ? EMPTY :
                  state_q == EMPTY ? (in_fire ? HALF : EMPTY) :
                  state_q == HALF  ? ((in_fire && !out_fire && SKID != 0) ? FULL :
                                      (out_fire && !in_fire) ? EMPTY : HALF) :
                  (out_fire ? HALF : FULL);
        main_d  = flush ? RESET_PAYLOAD :
                  state_q == FULL ? (out_fire ? skid_q : main_q) :
                  (in_fire && (state_q == EMPTY || out_fire)) ? in_data : main_q;
        skid_d  = flush ? RESET_PAYLOAD :
                  (SKID != 0 && state_q == HALF && in_fire && !out_fire) ? in_data : skid_q;
    end

    always_comb begin
        out_valid = state_q != EMPTY;
        out_data  = main_q;
        in_ready  = (SKID != 0) ? state_q != FULL : (state_q == EMPTY || out_ready);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    sat_counter #(.W(CNT_W)) u_stall (
        .clk   (clk),
        .reset (reset),
        .inc_i (out_valid && !out_ready),
        .clr_i (cnt_clr),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble (
        .clk   (clk),
        .reset (reset),
        .inc_i (!out_valid),
        .clr_i (cnt_clr),
        .cnt_o (bubble_cnt)
    );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: drives a skid instance (4-bit counters) and a single-register instance
// in parallel and checks both against queue-based reference models every cycle.
module tb_pipe_skid_reg;
    logic       clk = 1'b0;
    logic       reset, in_valid, out_ready, flush, cnt_clr;
    logic [7:0] in_data;
    logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [7:0] out_data_a, out_data_b;
    logic [3:0] stall_a, bubble_a;
    logic [15:0] stall_b, bubble_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int sa, ba, sb, bb;
    bit za, zb;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(8), .SKID(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .flush(flush),
        .stall_cnt(stall_a), .bubble_cnt(bubble_a), .cnt_clr(cnt_clr)
    );

    pipe_skid_reg #(.WIDTH(8), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .flush(flush),
        .stall_cnt(stall_b), .bubble_cnt(bubble_b), .cnt_clr(cnt_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        qa.delete(); qb.delete();
        sa = 0; ba = 0; sb = 0; bb = 0;
        za = 1; zb = 1;
    endtask

    task automatic check_all();
        chk("a_in_ready", 32'(in_ready_a), 32'(qa.size() < 2));
        chk("a_out_valid", 32'(out_valid_a), 32'(qa.size() > 0));
        if (qa.size() > 0) chk("a_out_data", 32'(out_data_a), 32'(qa[0]));
        else if (za) chk("a_out_data_rst", 32'(out_data_a), 32'h0);
        chk("a_stall", 32'(stall_a), 32'(sa));
        chk("a_bubble", 32'(bubble_a), 32'(ba));
        chk("b_in_ready", 32'(in_ready_b), 32'(qb.size() == 0 || out_ready));
        chk("b_ready_rule", 32'(in_ready_b), 32'(!out_valid_b || out_ready));
        chk("b_out_valid", 32'(out_valid_b), 32'(qb.size() > 0));
        if (qb.size() > 0) chk("b_out_data", 32'(out_data_b), 32'(qb[0]));
        else if (zb) chk("b_out_data_rst", 32'(out_data_b), 32'h0);
        chk("b_stall", 32'(stall_b), 32'(sb));
        chk("b_bubble", 32'(bubble_b), 32'(bb));
    endtask

    task automatic model_step();
        bit ina, outa, inb, outb;
        ina  = in_valid && qa.size() < 2;
        outa = qa.size() > 0 && out_ready;
        inb  = in_valid && (qb.size() == 0 || out_ready);
        outb = qb.size() > 0 && out_ready;
        if (cnt_clr) begin
            sa = 0; ba = 0; sb = 0; bb = 0;
        end else begin
            if (qa.size() > 0 && !out_ready && sa < 15) sa++;
            if (qa.size() == 0 && ba < 15) ba++;
            if (qb.size() > 0 && !out_ready && sb < 65535) sb++;
            if (qb.size() == 0 && bb < 65535) bb++;
        end
        if (flush) begin
            qa.delete(); qb.delete(); za = 1; zb = 1;
        end else begin
            if (outa) begin void'(qa.pop_front()); za = 0; end
            if (ina) qa.push_back(in_data);
            if (outb) begin void'(qb.pop_front()); zb = 0; end
            if (inb) qb.push_back(in_data);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        in_valid = v; in_data = d; out_ready = r;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_out_valid", 32'(out_valid_a), 32'h0);
        chk("rst_in_ready", 32'(in_ready_a), 32'h1);
        chk("rst_out_data", 32'(out_data_a), 32'h0);
        chk("rst_stall", 32'(stall_a), 32'h0);
        chk("rst_bubble", 32'(bubble_a), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        in_valid = 0; in_data = 0; out_ready = 0; flush = 0; cnt_clr = 0;
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b1);
        drive(1'b0, 8'h0, 1'b1);
        chk("stream_last", 32'(out_data_a), 32'h4);
        chk("stream_stall", 32'(stall_a), 32'h0);
        cnt_clr = 1;
        drive(1'b0, 8'h0, 1'b1);
        cnt_clr = 0;
        drive(1'b1, 8'hA, 1'b0);
        drive(1'b1, 8'hB, 1'b0);
        chk("bp_in_ready", 32'(in_ready_a), 32'h0);
        drive(1'b0, 8'h0, 1'b0);
        drive(1'b0, 8'h0, 1'b0);
        chk("bp_stall", 32'(stall_a), 32'h3);
        chk("bp_head", 32'(out_data_a), 32'hA);
        repeat (3) drive(1'b0, 8'h0, 1'b1);
        drive(1'b1, 8'hA, 1'b0);
        drive(1'b1, 8'hB, 1'b0);
        flush = 1;
        drive(1'b1, 8'hC, 1'b0);
        flush = 0;
        chk("flush_valid", 32'(out_valid_a), 32'h0);
        chk("flush_data", 32'(out_data_a), 32'h0);
        chk("flush_ready", 32'(in_ready_a), 32'h1);
        repeat (3) drive(1'b0, 8'h0, 1'b1);
        cnt_clr = 1;
        drive(1'b0, 8'h0, 1'b1);
        cnt_clr = 0;
        repeat (20) drive(1'b0, 8'h0, 1'b1);
        chk("sat_bubble", 32'(bubble_a), 32'hF);
        cnt_clr = 1;
        drive(1'b0, 8'h0, 1'b1);
        cnt_clr = 0;
        chk("clr_bubble", 32'(bubble_a), 32'h0);
        drive(1'b1, 8'h1, 1'b0);
        drive(1'b1, 8'h2, 1'b0);
        chk("pre_rst_full", 32'(in_ready_a), 32'h0);
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            flush   = ($urandom_range(0, 49) == 0);
            cnt_clr = ($urandom_range(0, 99) == 0);
            drive(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        flush = 0; cnt_clr = 0;
        repeat (3) drive(1'b0, 8'h0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline-stage register replacing the bare stage structs between fetch/decode/execute/memory/writeback. Moves one WIDTH-bit payload, e.g. a packed decode_data_t, between stages with a valid/ready handshake, stall back-pressure, flush and optional skid buffering. Each stage boundary instantiates one copy. Built-in saturating stall and bubble counters feed performance debug.

Parameters:
WIDTH, 64, payload width in bits; instantiate with $bits of the stage struct.
SKID, 1, 1 = two-entry skid buffer (in_ready registered); 0 = single register (in_ready combinational).
CNT_W, 16, width of stall and bubble counters.
RESET_PAYLOAD, '0, payload value loaded on reset and flush.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept a payload this cycle.
in_data  in  WIDTH  upstream payload.
out_valid  out  1  payload available downstream.
out_ready  in  1  downstream accepts this cycle.
out_data  out  WIDTH  payload to downstream.
flush  in  1  discard all held payloads (branch/jump redirect).
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready.
bubble_cnt  out  CNT_W  cycles with !out_valid.
cnt_clr  in  1  synchronous clear of both counters.

Behaviour:
- Reset (async assert, sync release): main_valid=0, skid_valid=0, out_valid=0, out_data=RESET_PAYLOAD, in_ready=1, stall_cnt=0, bubble_cnt=0.
- Transfer rules: input fires when in_valid && in_ready; output fires when out_valid && out_ready. Payload must not change while held and unaccepted.
- Latency: 1 cycle from input fire to out_valid. Full throughput (1 payload/cycle) when out_ready is held high.
- SKID=1: main register plus skid register.
  - in_ready = !skid_valid, a registered signal.
  - Input fires while main is full and the output does not fire: payload goes to skid.
  - Output fires while skid is full: skid moves to main, skid_valid falls, in_ready=1 next cycle.
  - Output and input fire together with main full and skid empty: in_data goes straight to main.
  - Never drop or duplicate a payload. FIFO order is always preserved.
- SKID=0: single main register.
  - in_ready = !main_valid || out_ready, combinational from out_ready.
  - Simultaneous fire replaces main.
- States for SKID=1: EMPTY (main=0, skid=0), HALF (1,0), FULL (1,1).
  - EMPTY -> HALF on input fire.
  - HALF -> FULL on input fire without output fire.
  - HALF -> EMPTY on output fire without input fire.
  - FULL -> HALF on output fire. Input cannot fire in FULL.
- Flush has highest priority. On flush, next cycle is EMPTY with both valids 0 and data=RESET_PAYLOAD. An input fire in the flush cycle is discarded, as is any output fire already in progress; downstream must also honour the flush it receives. in_ready during the flush cycle follows the normal rule.
- Counters:
  - stall_cnt increments when out_valid && !out_ready.
  - bubble_cnt increments when !out_valid.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr zeroes both next cycle and takes priority over an increment.
  - Flush does not clear the counters. Reset does.
- Reset asserted mid-transfer clears everything immediately. A payload is never partially visible.

Decomposition:
- Add to package pipes: a stage_hs_t struct (valid, ready), a perf_cnt_t typedef sized by CNT_W default, and localparams for per-stage widths ($bits of fetch_data_t, decode_data_t, execute_data_t, memory_data_t, writeback_data_t).
- One natural sub-module, sat_counter (parametrised width, inc, clr), instantiated twice.

Test Plan:
- Reset mid-stream: assert reset with main and skid full -> same cycle out_valid=0, in_ready=1, out_data=0, counters 0.
- Streaming: SKID=1, in_valid=1, out_ready=1, data 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles from cycle 1; stall_cnt=0.
- Back-pressure: send 0xA, 0xB with out_ready=0 -> in_ready=0 after 2 accepts, stall_cnt counts 1 per cycle. Raise out_ready -> 0xA then 0xB emerge, no loss.
- Flush: FULL state, pulse flush with in_valid=1 and data 0xC -> next cycle out_valid=0; 0xA, 0xB, 0xC never appear.
- Saturation: CNT_W=4, idle 20 cycles -> bubble_cnt holds 15. Then cnt_clr -> 0.
- SKID=0 random valid/ready for 1000 cycles -> scoreboard in-order match, and in_ready equals !out_valid || out_ready every cycle.
